// File: rtl/mem_axi_window.sv
// AXI4 address-window stage: rebases in-window AR/AW onto the output window,
// answers out-of-window requests locally with DECERR so they never reach the PS.

module mem_axi_window_ax_slice #(
  parameter int W = 51
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] in_pay,
  input  logic         out_ready,
  output logic         full,
  output logic [W-1:0] out_pay
);
  logic         full_q, full_d;
  logic [W-1:0] pay_q, pay_d;

  always_comb begin
    full_d = full_q;
    pay_d  = pay_q;
    if (load) begin
      full_d = 1'b1;
      pay_d  = in_pay;
    end else if (out_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      pay_q  <= '0;
    end else begin
      full_q <= full_d;
      pay_q  <= pay_d;
    end
  end

  assign full    = full_q;
  assign out_pay = pay_q;
endmodule

module mem_axi_window #(
  parameter logic [31:0] IN_BASE  = 32'h8000_0000,
  parameter logic [31:0] OUT_BASE = 32'h1000_0000,
  parameter int          WIN_BITS = 28
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        up_aw_valid,
  output logic        up_aw_ready,
  input  logic [31:0] up_aw_addr,
  input  logic [5:0]  up_aw_id,
  input  logic [7:0]  up_aw_len,
  input  logic [2:0]  up_aw_size,
  input  logic [1:0]  up_aw_burst,
  input  logic        up_ar_valid,
  output logic        up_ar_ready,
  input  logic [31:0] up_ar_addr,
  input  logic [5:0]  up_ar_id,
  input  logic [7:0]  up_ar_len,
  input  logic [2:0]  up_ar_size,
  input  logic [1:0]  up_ar_burst,
  input  logic        up_w_valid,
  output logic        up_w_ready,
  input  logic [63:0] up_w_data,
  input  logic [7:0]  up_w_strb,
  input  logic        up_w_last,
  output logic        up_b_valid,
  input  logic        up_b_ready,
  output logic [5:0]  up_b_id,
  output logic [1:0]  up_b_resp,
  output logic        up_r_valid,
  input  logic        up_r_ready,
  output logic [5:0]  up_r_id,
  output logic [63:0] up_r_data,
  output logic [1:0]  up_r_resp,
  output logic        up_r_last,
  output logic        dn_aw_valid,
  input  logic        dn_aw_ready,
  output logic [31:0] dn_aw_addr,
  output logic [5:0]  dn_aw_id,
  output logic [7:0]  dn_aw_len,
  output logic [2:0]  dn_aw_size,
  output logic [1:0]  dn_aw_burst,
  output logic        dn_ar_valid,
  input  logic        dn_ar_ready,
  output logic [31:0] dn_ar_addr,
  output logic [5:0]  dn_ar_id,
  output logic [7:0]  dn_ar_len,
  output logic [2:0]  dn_ar_size,
  output logic [1:0]  dn_ar_burst,
  output logic        dn_w_valid,
  input  logic        dn_w_ready,
  output logic [63:0] dn_w_data,
  output logic [7:0]  dn_w_strb,
  output logic        dn_w_last,
  input  logic        dn_b_valid,
  output logic        dn_b_ready,
  input  logic [5:0]  dn_b_id,
  input  logic [1:0]  dn_b_resp,
  input  logic        dn_r_valid,
  output logic        dn_r_ready,
  input  logic [5:0]  dn_r_id,
  input  logic [63:0] dn_r_data,
  input  logic [1:0]  dn_r_resp,
  input  logic        dn_r_last
);
  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ax_t;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_DROP, B_ERR} w_state_e;
  typedef enum logic {R_PASS, R_ERR} r_state_e;

  localparam int          AXW     = $bits(ax_t);
  localparam logic [4:0]  MAX_OUT = 5'd15;

  function automatic logic win_hit(input logic [31:0] a);
    return a[31:WIN_BITS] == IN_BASE[31:WIN_BITS];
  endfunction

  function automatic ax_t remap(input ax_t a);
    ax_t r;
    r      = a;
    r.addr = {OUT_BASE[31:WIN_BITS], a.addr[WIN_BITS-1:0]};
    return r;
  endfunction

  function automatic logic [3:0] step(input logic [3:0] c, input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + 4'd1;
      2'b01:   return c - 4'd1;
      default: return c;
    endcase
  endfunction

  // run_q holds every ready/valid low while in reset and kills them the
  // instant reset_n falls, without using reset_n as a data signal.
  logic       run_q, run_d;
  logic [3:0] rd_out_q, rd_out_d, wr_out_q, wr_out_d;
  r_state_e   r_state_q, r_state_d;
  logic [7:0] r_beats_q, r_beats_d;
  logic [5:0] r_id_q, r_id_d;
  w_state_e   w_state_q, w_state_d;
  logic [5:0] w_id_q, w_id_d;

  ax_t            ar_in, aw_in, ar_out, aw_out;
  logic [AXW-1:0] ar_out_raw, aw_out_raw;
  logic           ar_full, aw_full, ar_hit, aw_hit;
  logic [4:0]     ar_pend, aw_pend;
  logic           ar_load, ar_miss, aw_load, aw_acc;
  logic           dn_ar_hs, dn_aw_hs, rd_dec, wr_dec;

  assign ar_in  = '{up_ar_addr, up_ar_id, up_ar_len, up_ar_size, up_ar_burst};
  assign aw_in  = '{up_aw_addr, up_aw_id, up_aw_len, up_aw_size, up_aw_burst};
  assign ar_hit = win_hit(up_ar_addr);
  assign aw_hit = win_hit(up_aw_addr);

  // Count the request parked in the slice as outstanding too, so the 4-bit
  // counters can never wrap past 15.
  assign ar_pend = {1'b0, rd_out_q} + {4'b0, ar_full};
  assign aw_pend = {1'b0, wr_out_q} + {4'b0, aw_full};

  always_comb begin
    up_ar_ready = 1'b0;
    if (run_q && r_state_q == R_PASS) begin
      if (ar_hit) up_ar_ready = (!ar_full || dn_ar_ready) && (ar_pend < MAX_OUT);
      else        up_ar_ready = (ar_pend == 5'd0);
    end
  end

  always_comb begin
    up_aw_ready = 1'b0;
    if (run_q && w_state_q == W_IDLE) begin
      if (aw_hit) up_aw_ready = (!aw_full || dn_aw_ready) && (aw_pend < MAX_OUT);
      else        up_aw_ready = (aw_pend == 5'd0);
    end
  end

  assign ar_load  = up_ar_valid && up_ar_ready && ar_hit;
  assign ar_miss  = up_ar_valid && up_ar_ready && !ar_hit;
  assign aw_acc   = up_aw_valid && up_aw_ready;
  assign aw_load  = aw_acc && aw_hit;
  assign dn_ar_hs = ar_full && dn_ar_ready;
  assign dn_aw_hs = aw_full && dn_aw_ready;
  assign rd_dec   = dn_r_valid && dn_r_ready && dn_r_last;
  assign wr_dec   = dn_b_valid && dn_b_ready;

  mem_axi_window_ax_slice #(.W(AXW)) u_ar_slice (
    .clock(clock), .reset_n(reset_n), .load(ar_load), .in_pay(remap(ar_in)),
    .out_ready(dn_ar_ready), .full(ar_full), .out_pay(ar_out_raw)
  );

  mem_axi_window_ax_slice #(.W(AXW)) u_aw_slice (
    .clock(clock), .reset_n(reset_n), .load(aw_load), .in_pay(remap(aw_in)),
    .out_ready(dn_aw_ready), .full(aw_full), .out_pay(aw_out_raw)
  );

  assign ar_out      = ar_out_raw;
  assign aw_out      = aw_out_raw;
  assign dn_ar_valid = ar_full;
  assign dn_aw_valid = aw_full;
  assign {dn_ar_addr, dn_ar_id, dn_ar_len, dn_ar_size, dn_ar_burst} = ar_out;
  assign {dn_aw_addr, dn_aw_id, dn_aw_len, dn_aw_size, dn_aw_burst} = aw_out;

  always_comb begin
    run_d    = 1'b1;
    rd_out_d = step(rd_out_q, dn_ar_hs, rd_dec);
    wr_out_d = step(wr_out_q, dn_aw_hs, wr_dec);
  end

  always_comb begin
    r_state_d  = r_state_q;
    r_beats_d  = r_beats_q;
    r_id_d     = r_id_q;
    up_r_valid = 1'b0;
    up_r_id    = '0;
    up_r_data  = '0;
    up_r_resp  = '0;
    up_r_last  = 1'b0;
    dn_r_ready = 1'b0;
    if (run_q) begin
      if (r_state_q == R_ERR) begin
        up_r_valid = 1'b1;
        up_r_id    = r_id_q;
        up_r_resp  = 2'b11;
        up_r_last  = (r_beats_q == 8'd0);
        if (up_r_ready) begin
          if (r_beats_q == 8'd0) r_state_d = R_PASS;
          else                   r_beats_d = r_beats_q - 8'd1;
        end
      end else begin
        up_r_valid = dn_r_valid;
        up_r_id    = dn_r_id;
        up_r_data  = dn_r_data;
        up_r_resp  = dn_r_resp;
        up_r_last  = dn_r_last;
        dn_r_ready = up_r_ready;
      end
    end
    if (ar_miss) begin
      r_state_d = R_ERR;
      r_beats_d = up_ar_len;
      r_id_d    = up_ar_id;
    end
  end

  always_comb begin
    w_state_d  = w_state_q;
    w_id_d     = w_id_q;
    dn_w_valid = 1'b0;
    dn_w_data  = '0;
    dn_w_strb  = '0;
    dn_w_last  = 1'b0;
    up_w_ready = 1'b0;
    up_b_valid = 1'b0;
    up_b_id    = '0;
    up_b_resp  = '0;
    dn_b_ready = 1'b0;
    if (run_q) begin
      case (w_state_q)
        W_IDLE: if (aw_acc) begin
          w_state_d = aw_hit ? W_FWD : W_DROP;
          if (!aw_hit) w_id_d = up_aw_id;
        end
        W_FWD: begin
          dn_w_valid = up_w_valid;
          dn_w_data  = up_w_data;
          dn_w_strb  = up_w_strb;
          dn_w_last  = up_w_last;
          up_w_ready = dn_w_ready;
          if (up_w_valid && dn_w_ready && up_w_last) w_state_d = W_IDLE;
        end
        W_DROP: begin
          up_w_ready = 1'b1;
          if (up_w_valid && up_w_last) w_state_d = B_ERR;
        end
        B_ERR: begin
          up_b_valid = 1'b1;
          up_b_id    = w_id_q;
          up_b_resp  = 2'b11;
          if (up_b_ready) w_state_d = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
      if (w_state_q != B_ERR) begin
        up_b_valid = dn_b_valid;
        up_b_id    = dn_b_id;
        up_b_resp  = dn_b_resp;
        dn_b_ready = up_b_ready;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      rd_out_q  <= '0;
      wr_out_q  <= '0;
      r_state_q <= R_PASS;
      r_beats_q <= '0;
      r_id_q    <= '0;
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      run_q     <= run_d;
      rd_out_q  <= rd_out_d;
      wr_out_q  <= wr_out_d;
      r_state_q <= r_state_d;
      r_beats_q <= r_beats_d;
      r_id_q    <= r_id_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
    end
  end
endmodule

// File: tb/tb_mem_axi_window.sv
// Directed bench for mem_axi_window: a transaction-level model checked every
// cycle, plus literal expectations from the hand-worked scenarios.

module tb_mem_axi_window;
  localparam logic [31:0] IN_BASE  = 32'h8000_0000;
  localparam logic [31:0] OUT_BASE = 32'h1000_0000;
  localparam int          WIN_BITS = 28;

  logic clock = 1'b0, reset_n = 1'b0;
  logic up_aw_valid, up_aw_ready, up_ar_valid, up_ar_ready;
  logic [31:0] up_aw_addr, up_ar_addr, dn_aw_addr, dn_ar_addr;
  logic [5:0] up_aw_id, up_ar_id, dn_aw_id, dn_ar_id;
  logic [7:0] up_aw_len, up_ar_len, dn_aw_len, dn_ar_len;
  logic [2:0] up_aw_size, up_ar_size, dn_aw_size, dn_ar_size;
  logic [1:0] up_aw_burst, up_ar_burst, dn_aw_burst, dn_ar_burst;
  logic up_w_valid, up_w_ready, up_w_last, dn_w_valid, dn_w_ready, dn_w_last;
  logic [63:0] up_w_data, dn_w_data, up_r_data, dn_r_data;
  logic [7:0] up_w_strb, dn_w_strb;
  logic up_b_valid, up_b_ready, dn_b_valid, dn_b_ready;
  logic [5:0] up_b_id, dn_b_id, up_r_id, dn_r_id;
  logic [1:0] up_b_resp, dn_b_resp, up_r_resp, dn_r_resp;
  logic up_r_valid, up_r_ready, up_r_last, dn_r_valid, dn_r_ready, dn_r_last;
  logic dn_aw_valid, dn_aw_ready, dn_ar_valid, dn_ar_ready;

  mem_axi_window #(.IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE), .WIN_BITS(WIN_BITS)) dut (
    .clock(clock), .reset_n(reset_n),
    .up_aw_valid(up_aw_valid), .up_aw_ready(up_aw_ready), .up_aw_addr(up_aw_addr),
    .up_aw_id(up_aw_id), .up_aw_len(up_aw_len), .up_aw_size(up_aw_size), .up_aw_burst(up_aw_burst),
    .up_ar_valid(up_ar_valid), .up_ar_ready(up_ar_ready), .up_ar_addr(up_ar_addr),
    .up_ar_id(up_ar_id), .up_ar_len(up_ar_len), .up_ar_size(up_ar_size), .up_ar_burst(up_ar_burst),
    .up_w_valid(up_w_valid), .up_w_ready(up_w_ready), .up_w_data(up_w_data),
    .up_w_strb(up_w_strb), .up_w_last(up_w_last),
    .up_b_valid(up_b_valid), .up_b_ready(up_b_ready), .up_b_id(up_b_id), .up_b_resp(up_b_resp),
    .up_r_valid(up_r_valid), .up_r_ready(up_r_ready), .up_r_id(up_r_id), .up_r_data(up_r_data),
    .up_r_resp(up_r_resp), .up_r_last(up_r_last),
    .dn_aw_valid(dn_aw_valid), .dn_aw_ready(dn_aw_ready), .dn_aw_addr(dn_aw_addr),
    .dn_aw_id(dn_aw_id), .dn_aw_len(dn_aw_len), .dn_aw_size(dn_aw_size), .dn_aw_burst(dn_aw_burst),
    .dn_ar_valid(dn_ar_valid), .dn_ar_ready(dn_ar_ready), .dn_ar_addr(dn_ar_addr),
    .dn_ar_id(dn_ar_id), .dn_ar_len(dn_ar_len), .dn_ar_size(dn_ar_size), .dn_ar_burst(dn_ar_burst),
    .dn_w_valid(dn_w_valid), .dn_w_ready(dn_w_ready), .dn_w_data(dn_w_data),
    .dn_w_strb(dn_w_strb), .dn_w_last(dn_w_last),
    .dn_b_valid(dn_b_valid), .dn_b_ready(dn_b_ready), .dn_b_id(dn_b_id), .dn_b_resp(dn_b_resp),
    .dn_r_valid(dn_r_valid), .dn_r_ready(dn_r_ready), .dn_r_id(dn_r_id), .dn_r_data(dn_r_data),
    .dn_r_resp(dn_r_resp), .dn_r_last(dn_r_last)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [31:0] addr; logic [5:0] id; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
  } ax_t;
  typedef struct packed { logic [5:0] id; logic last; } rb_t;

  ax_t arq[$], awq[$];
  rb_t rq[$];
  logic [5:0] bq[$];
  int rd_pend = 0, wr_pend = 0, wmode = 0;  // wmode: 0 idle, 1 forward, 2 drop
  logic [5:0] drop_id;

  function automatic bit m_hit(input logic [31:0] a);
    return ((a ^ IN_BASE) >> WIN_BITS) == 0;
  endfunction
  function automatic logic [31:0] m_remap(input logic [31:0] a);
    logic [31:0] mask;
    mask = (32'h1 << WIN_BITS) - 32'h1;
    return OUT_BASE | (a & mask);
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_outputs", {up_aw_ready, up_ar_ready, up_w_ready, up_b_valid, up_r_valid,
                          dn_aw_valid, dn_ar_valid, dn_w_valid, dn_b_ready, dn_r_ready}, 0);
      arq.delete(); awq.delete(); rq.delete(); bq.delete();
      rd_pend = 0; wr_pend = 0; wmode = 0;
    end else begin
      // address channels
      chk("dn_ar_valid", dn_ar_valid, arq.size() != 0);
      if (dn_ar_valid && arq.size() != 0)
        chk("dn_ar_pay", {dn_ar_addr, dn_ar_id, dn_ar_len, dn_ar_size, dn_ar_burst}, arq[0]);
      chk("dn_aw_valid", dn_aw_valid, awq.size() != 0);
      if (dn_aw_valid && awq.size() != 0)
        chk("dn_aw_pay", {dn_aw_addr, dn_aw_id, dn_aw_len, dn_aw_size, dn_aw_burst}, awq[0]);
      if (up_ar_valid && (rq.size() != 0 || (m_hit(up_ar_addr) && rd_pend >= 15) ||
                          (!m_hit(up_ar_addr) && rd_pend != 0)))
        chk("up_ar_block", up_ar_ready, 0);
      if (up_aw_valid && (wmode != 0 || bq.size() != 0 || (m_hit(up_aw_addr) && wr_pend >= 15) ||
                          (!m_hit(up_aw_addr) && wr_pend != 0)))
        chk("up_aw_block", up_aw_ready, 0);
      // read data
      if (rq.size() != 0) begin
        chk("rerr_valid", up_r_valid, 1);
        chk("rerr_pay", {up_r_id, up_r_data, up_r_resp, up_r_last}, {rq[0].id, 64'h0, 2'b11, rq[0].last});
        chk("rerr_dn_ready", dn_r_ready, 0);
      end else begin
        chk("r_pass_valid", up_r_valid, dn_r_valid);
        if (dn_r_valid) begin
          chk("r_pass_pay", {up_r_id, up_r_data, up_r_resp, up_r_last}, {dn_r_id, dn_r_data, dn_r_resp, dn_r_last});
          chk("r_pass_ready", dn_r_ready, up_r_ready);
        end
      end
      // write data
      if (wmode == 1) begin
        chk("w_fwd_valid", dn_w_valid, up_w_valid);
        if (up_w_valid) begin
          chk("w_fwd_pay", {dn_w_data, dn_w_strb, dn_w_last}, {up_w_data, up_w_strb, up_w_last});
          chk("w_fwd_ready", up_w_ready, dn_w_ready);
        end
      end else if (wmode == 2) begin
        chk("w_drop", {dn_w_valid, up_w_ready}, 2'b01);
      end else begin
        chk("w_idle", {dn_w_valid, up_w_ready}, 2'b00);
      end
      // write response
      if (bq.size() != 0) begin
        chk("berr", {up_b_valid, up_b_id, up_b_resp, dn_b_ready}, {1'b1, bq[0], 2'b11, 1'b0});
      end else begin
        chk("b_pass_valid", up_b_valid, dn_b_valid);
        if (dn_b_valid) begin
          chk("b_pass_pay", {up_b_id, up_b_resp}, {dn_b_id, dn_b_resp});
          chk("b_pass_ready", dn_b_ready, up_b_ready);
        end
      end
      // advance model with the handshakes about to happen on the next edge
      if (rq.size() != 0) begin
        if (up_r_ready) void'(rq.pop_front());
      end else if (dn_r_valid && dn_r_ready && dn_r_last) rd_pend--;
      if (dn_ar_valid && dn_ar_ready && arq.size() != 0) void'(arq.pop_front());
      if (up_ar_valid && up_ar_ready) begin
        if (m_hit(up_ar_addr)) begin
          arq.push_back('{m_remap(up_ar_addr), up_ar_id, up_ar_len, up_ar_size, up_ar_burst});
          rd_pend++;
        end else begin
          for (int i = 0; i <= int'(up_ar_len); i++) begin
            rb_t e;
            e.id = up_ar_id; e.last = (i == int'(up_ar_len));
            rq.push_back(e);
          end
        end
      end
      if (bq.size() != 0) begin
        if (up_b_ready) void'(bq.pop_front());
      end else if (dn_b_valid && dn_b_ready) wr_pend--;
      if (up_w_valid && up_w_ready && up_w_last) begin
        if (wmode == 2) bq.push_back(drop_id);
        wmode = 0;
      end
      if (dn_aw_valid && dn_aw_ready && awq.size() != 0) void'(awq.pop_front());
      if (up_aw_valid && up_aw_ready) begin
        if (m_hit(up_aw_addr)) begin
          awq.push_back('{m_remap(up_aw_addr), up_aw_id, up_aw_len, up_aw_size, up_aw_burst});
          wr_pend++;
          wmode = 1;
        end else begin
          drop_id = up_aw_id;
          wmode = 2;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv_ar(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    up_ar_valid = 1; up_ar_addr = a; up_ar_id = id; up_ar_len = len; up_ar_size = 3'd3; up_ar_burst = 2'd1;
  endtask
  task automatic wait_ar();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clock); ok = up_ar_ready; end
    if (!ok) chk("ar_timeout", 0, 1);
    @(posedge clock); #1; up_ar_valid = 0;
  endtask
  task automatic drv_aw(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    up_aw_valid = 1; up_aw_addr = a; up_aw_id = id; up_aw_len = len; up_aw_size = 3'd3; up_aw_burst = 2'd1;
  endtask
  task automatic wait_aw();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clock); ok = up_aw_ready; end
    if (!ok) chk("aw_timeout", 0, 1);
    @(posedge clock); #1; up_aw_valid = 0;
  endtask
  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    bit ok;
    ok = 0;
    up_w_valid = 1; up_w_data = d; up_w_strb = s; up_w_last = l;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clock); ok = up_w_ready; end
    if (!ok) chk("w_timeout", 0, 1);
    @(posedge clock); #1; up_w_valid = 0;
  endtask
  task automatic send_r(input logic [5:0] id, input logic [63:0] d, input logic l);
    bit ok;
    ok = 0;
    dn_r_valid = 1; dn_r_id = id; dn_r_data = d; dn_r_resp = 2'b00; dn_r_last = l;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clock); ok = dn_r_ready; end
    if (!ok) chk("r_timeout", 0, 1);
    else chk("r_hit_data", up_r_data, d);
    @(posedge clock); #1; dn_r_valid = 0;
  endtask
  task automatic send_b(input logic [5:0] id, input logic [1:0] resp);
    bit ok;
    ok = 0;
    dn_b_valid = 1; dn_b_id = id; dn_b_resp = resp;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clock); ok = dn_b_ready; end
    if (!ok) chk("b_timeout", 0, 1);
    else chk("b_hit_pay", {up_b_id, up_b_resp}, {id, resp});
    @(posedge clock); #1; dn_b_valid = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int nb, lastidx;
    bit ok;
    up_aw_valid = 0; up_aw_addr = 0; up_aw_id = 0; up_aw_len = 0; up_aw_size = 0; up_aw_burst = 0;
    up_ar_valid = 0; up_ar_addr = 0; up_ar_id = 0; up_ar_len = 0; up_ar_size = 0; up_ar_burst = 0;
    up_w_valid = 0; up_w_data = 0; up_w_strb = 0; up_w_last = 0;
    up_b_ready = 1; up_r_ready = 1;
    dn_aw_ready = 1; dn_ar_ready = 1; dn_w_ready = 1;
    dn_b_valid = 0; dn_b_id = 0; dn_b_resp = 0;
    dn_r_valid = 0; dn_r_id = 0; dn_r_data = 0; dn_r_resp = 0; dn_r_last = 0;

    // reset: readies held low even with a valid hit request presented
    #12;
    drv_ar(32'h8000_0000, 6'd1, 8'd0);
    drv_aw(32'h8000_0000, 6'd1, 8'd0);
    #1;
    chk("rst_ar_ready", up_ar_ready, 0);
    chk("rst_aw_ready", up_aw_ready, 0);
    chk("rst_valids", {dn_ar_valid, dn_aw_valid, up_r_valid, up_b_valid}, 0);
    up_ar_valid = 0; up_aw_valid = 0;
    @(negedge clock); #1 reset_n = 1;
    repeat (2) @(posedge clock);
    #1;

    // read hit
    drv_ar(32'h8000_1040, 6'd5, 8'd3);
    wait_ar();
    chk("rd_hit_dn_ar", {dn_ar_valid, dn_ar_addr, dn_ar_id, dn_ar_len}, {1'b1, 32'h1000_1040, 6'd5, 8'd3});
    for (int i = 0; i < 4; i++) send_r(6'd5, 64'hA0 + 64'(i), i == 3);

    // write hit
    drv_aw(32'h8FFF_FFF8, 6'd3, 8'd0);
    wait_aw();
    chk("wr_hit_dn_aw", {dn_aw_valid, dn_aw_addr, dn_aw_id}, {1'b1, 32'h1FFF_FFF8, 6'd3});
    send_w(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
    send_b(6'd3, 2'b00);

    // read miss with a 3-cycle stall
    drv_ar(32'h7FFF_FFC0, 6'd9, 8'd7);
    wait_ar();
    nb = 0; lastidx = -1;
    for (int c = 0; c < 30 && nb < 8; c++) begin
      @(negedge clock);
      if (up_r_valid && up_r_ready) begin
        if (up_r_last) lastidx = nb;
        nb++;
      end
      @(posedge clock); #1;
      up_r_ready = !(c >= 2 && c < 5);
    end
    up_r_ready = 1;
    chk("rd_miss_beats", nb, 8);
    chk("rd_miss_last_idx", lastidx, 7);
    chk("rd_miss_no_dn_ar", dn_ar_valid, 0);

    // write miss queued behind an outstanding hit write
    drv_aw(32'h8000_0100, 6'd4, 8'd0);
    wait_aw();
    send_w(64'h1111, 8'h0F, 1'b1);
    drv_aw(32'h0000_0000, 6'd7, 8'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("wr_miss_held", up_aw_ready, 0);
    end
    @(posedge clock); #1;
    send_b(6'd4, 2'b00);
    wait_aw();
    send_w(64'h2222, 8'hFF, 1'b0);
    send_w(64'h3333, 8'hFF, 1'b1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (up_b_valid) begin
        ok = 1;
        chk("wr_miss_b", {up_b_id, up_b_resp}, {6'd7, 2'b11});
      end
    end
    if (!ok) chk("wr_miss_b_timeout", 0, 1);
    @(posedge clock); #1;

    // read credit limit: 15 outstanding hits block the 16th
    for (int i = 0; i < 15; i++) begin
      drv_ar(32'h8000_2000 + 32'(i * 64), 6'(i), 8'd0);
      wait_ar();
    end
    drv_ar(32'h8000_3000, 6'd20, 8'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("credit_block", up_ar_ready, 0);
    end
    @(posedge clock); #1;
    send_r(6'd0, 64'h55, 1'b1);
    wait_ar();
    for (int i = 1; i < 16; i++) send_r(6'(i), 64'h100 + 64'(i), 1'b1);

    // reset during an error burst
    drv_ar(32'h0000_0040, 6'd2, 8'd3);
    wait_ar();
    @(posedge clock); @(posedge clock);
    #2 reset_n = 0;
    #1;
    chk("midrst_valids", {up_r_valid, up_b_valid, dn_ar_valid, dn_aw_valid, dn_w_valid}, 0);
    chk("midrst_readies", {up_ar_ready, up_aw_ready, up_w_ready}, 0);
    @(posedge clock);
    @(negedge clock); #1 reset_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_no_beat", up_r_valid, 0);
    end

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
